nv_nvdla_cvif_read_eg_rtn: RTL and testbench

//  CVIF read-return egress. Consumes the per-thread context written at AR issue (cq_wr_*) and NoC AXI R beats.

---
 rtl/nv_nvdla_cvif_read_eg_rtn.sv | 146 ++++++++++++++
 tb/tb_nv_nvdla_cvif_read_eg_rtn.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cvif_read_eg_rtn.sv
// CVIF read-return egress: routes AXI R beats to per-client 2-entry skid buffers using per-thread burst context.
// Optional protocol checking is enabled by defining CVIF_RD_EG_ERR_CHK_EN.
module nv_nvdla_cvif_read_eg_rtn #(
    parameter int NUM_CLIENTS = 10,
    parameter int DATA_W      = 512,
    parameter int CQ_DEPTH    = 4
) (
    input  logic                                nvdla_core_clk,
    input  logic                                nvdla_core_rst,
    input  logic                                cq_wr_pvld,
    output logic                                cq_wr_prdy,
    input  logic [3:0]                          cq_wr_thread_id,
    input  logic [6:0]                          cq_wr_pd,
    input  logic                                noc2cvif_axi_r_rvalid,
    output logic                                noc2cvif_axi_r_rready,
    input  logic [7:0]                          noc2cvif_axi_r_rid,
    input  logic                                noc2cvif_axi_r_rlast,
    input  logic [DATA_W-1:0]                   noc2cvif_axi_r_rdata,
    output logic [NUM_CLIENTS-1:0]              rsp_valid,
    input  logic [NUM_CLIENTS-1:0]              rsp_ready,
    output logic [NUM_CLIENTS*(DATA_W+2)-1:0]   rsp_pd,
    output logic                                eg2ig_axi_vld,
    output logic                                eg_err
);
    localparam int PW = DATA_W + 2;
    localparam int AW = $clog2(CQ_DEPTH);
    localparam logic [4:0] NUM_C5 = 5'(NUM_CLIENTS);

    logic [3:0]             r_thread;
    logic                   r_in_range;
    logic                   cq_in_range;
    logic                   r_fire;
    logic                   cq_push;
    logic                   rready_int;
    logic [NUM_CLIENTS-1:0] ctx_full;
    logic [NUM_CLIENTS-1:0] ctx_nempty;
    logic [NUM_CLIENTS-1:0] skid_room;
    logic [NUM_CLIENTS-1:0] client_err;
    logic [15:0]            ctx_full_pad;
    logic [15:0]            ctx_nempty_pad;
    logic [15:0]            skid_room_pad;
    logic                   unused_in;

    assign unused_in      = ^{cq_wr_pd[6], noc2cvif_axi_r_rid[7:4]};
    assign r_thread       = noc2cvif_axi_r_rid[3:0];
    assign r_in_range     = {1'b0, r_thread} < NUM_C5;
    assign cq_in_range    = {1'b0, cq_wr_thread_id} < NUM_C5;
    assign ctx_full_pad   = 16'(ctx_full);
    assign ctx_nempty_pad = 16'(ctx_nempty);
    assign skid_room_pad  = 16'(skid_room);

    // Out-of-range ids are always accepted so a stray beat can never wedge the R channel.
    assign rready_int            = r_in_range ? (skid_room_pad[r_thread] & ctx_nempty_pad[r_thread]) : 1'b1;
    assign noc2cvif_axi_r_rready = ~nvdla_core_rst & rready_int;
    assign cq_wr_prdy            = ~nvdla_core_rst & ~ctx_full_pad[cq_wr_thread_id];
    assign r_fire                = noc2cvif_axi_r_rvalid & noc2cvif_axi_r_rready;
    assign cq_push               = cq_wr_pvld & cq_wr_prdy & cq_in_range;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cli
        logic [5:0]    ctx_mem [CQ_DEPTH];
        logic [AW:0]   ctx_wp, ctx_rp;
        logic [5:0]    head;
        logic [3:0]    cnt;
        logic          push, beat, pop, illegal;
        logic [1:0]    mask;
        logic [PW-1:0] skid_mem [2];
        logic          skid_wp, skid_rp;
        logic [1:0]    skid_cnt;
        logic          skid_pop;

        assign push        = cq_push & (cq_wr_thread_id == 4'(i));
        assign beat        = r_fire & r_in_range & (r_thread == 4'(i));
        assign pop         = beat & noc2cvif_axi_r_rlast;
        assign head        = ctx_mem[ctx_rp[AW-1:0]];
        assign ctx_full[i]   = (ctx_wp - ctx_rp) == (AW+1)'(CQ_DEPTH);
        assign ctx_nempty[i] = ctx_wp != ctx_rp;
        assign illegal     = (cnt == 4'd0) & head[4] & noc2cvif_axi_r_rlast & head[5];

        always_comb begin
            mask = 2'b11;
            if (illegal)                                mask = 2'b11;
            else if ((cnt == 4'd0) && head[4])          mask = 2'b10;
            else if (noc2cvif_axi_r_rlast && head[5])   mask = 2'b01;
        end

        assign skid_pop     = (skid_cnt != 2'd0) & rsp_ready[i];
        assign skid_room[i] = (skid_cnt != 2'd2) | rsp_ready[i];
        assign rsp_valid[i] = skid_cnt != 2'd0;
        assign rsp_pd[i*PW +: PW] = skid_mem[skid_rp];

`ifdef CVIF_RD_EG_ERR_CHK_EN
        assign client_err[i] = beat & (illegal |
                               (noc2cvif_axi_r_rlast  & (cnt != head[3:0])) |
                               (~noc2cvif_axi_r_rlast & (cnt == head[3:0])));
`else
        logic unused_beats;
        assign unused_beats  = ^{head[3:0], illegal};
        assign client_err[i] = 1'b0;
`endif

        always_ff @(posedge nvdla_core_clk) begin
            if (push) ctx_mem[ctx_wp[AW-1:0]] <= cq_wr_pd[5:0];
            if (beat) skid_mem[skid_wp]       <= {mask, noc2cvif_axi_r_rdata};
        end

        always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst) begin
                ctx_wp   <= '0;
                ctx_rp   <= '0;
                cnt      <= '0;
                skid_wp  <= 1'b0;
                skid_rp  <= 1'b0;
                skid_cnt <= 2'd0;
            end else begin
                if (push)     ctx_wp  <= ctx_wp + 1'b1;
                if (pop)      ctx_rp  <= ctx_rp + 1'b1;
                if (beat)     cnt     <= noc2cvif_axi_r_rlast ? 4'd0 : cnt + 4'd1;
                if (beat)     skid_wp <= ~skid_wp;
                if (skid_pop) skid_rp <= ~skid_rp;
                case ({beat, skid_pop})
                    2'b10:   skid_cnt <= skid_cnt + 2'd1;
                    2'b01:   skid_cnt <= skid_cnt - 2'd1;
                    default: skid_cnt <= skid_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) eg2ig_axi_vld <= 1'b0;
        else                eg2ig_axi_vld <= r_fire & r_in_range & noc2cvif_axi_r_rlast;
    end

`ifdef CVIF_RD_EG_ERR_CHK_EN
    logic err_q;
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) err_q <= 1'b0;
        else                err_q <= err_q | (r_fire & ~r_in_range) | (|client_err);
    end
    assign eg_err = err_q;
`else
    logic unused_err;
    assign unused_err = ^client_err;
    assign eg_err     = 1'b0;
`endif
endmodule

// File: tb/tb_nv_nvdla_cvif_read_eg_rtn.sv
// Directed bench for nv_nvdla_cvif_read_eg_rtn; eg_err expectations follow CVIF_RD_EG_ERR_CHK_EN.
module tb_nv_nvdla_cvif_read_eg_rtn;
    localparam int NC = 10;
    localparam int DW = 16;
    localparam int PW = DW + 2;
`ifdef CVIF_RD_EG_ERR_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cq_wr_pvld;
    logic             cq_wr_prdy;
    logic [3:0]       cq_wr_thread_id;
    logic [6:0]       cq_wr_pd;
    logic             rvalid;
    logic             rready;
    logic [7:0]       rid;
    logic             rlast;
    logic [DW-1:0]    rdata;
    logic [NC-1:0]    rsp_valid;
    logic [NC-1:0]    rsp_ready;
    logic [NC*PW-1:0] rsp_pd;
    logic             eg2ig_axi_vld;
    logic             eg_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nv_nvdla_cvif_read_eg_rtn #(.NUM_CLIENTS(NC), .DATA_W(DW), .CQ_DEPTH(4)) dut (
        .nvdla_core_clk        (clk),
        .nvdla_core_rst        (rst),
        .cq_wr_pvld            (cq_wr_pvld),
        .cq_wr_prdy            (cq_wr_prdy),
        .cq_wr_thread_id       (cq_wr_thread_id),
        .cq_wr_pd              (cq_wr_pd),
        .noc2cvif_axi_r_rvalid (rvalid),
        .noc2cvif_axi_r_rready (rready),
        .noc2cvif_axi_r_rid    (rid),
        .noc2cvif_axi_r_rlast  (rlast),
        .noc2cvif_axi_r_rdata  (rdata),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_pd                (rsp_pd),
        .eg2ig_axi_vld         (eg2ig_axi_vld),
        .eg_err                (eg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pd_of(input int i);
        logic [NC*PW-1:0] sh;
        sh = rsp_pd >> (i * PW);
        return sh[PW-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ctx_write(input logic [3:0] t, input logic [6:0] pd, input logic exp_rdy);
        cq_wr_pvld      = 1'b1;
        cq_wr_thread_id = t;
        cq_wr_pd        = pd;
        #1;
        chk("cq_wr_prdy", 32'(cq_wr_prdy), 32'(exp_rdy));
        tick();
        cq_wr_pvld = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] id, input logic [DW-1:0] d, input logic last);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rlast  = last;
        #1;
        chk("rready", 32'(rready), 32'd1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cq_wr_pvld = 1'b0; cq_wr_thread_id = '0; cq_wr_pd = '0;
        rvalid = 1'b0; rid = '0; rlast = 1'b0; rdata = '0; rsp_ready = '1;

        // reset: handshakes forced low while reset is high
        tick();
        rvalid = 1'b1; rid = 8'h0C; cq_wr_pvld = 1'b1;
        #1;
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_prdy", 32'(cq_wr_prdy), 32'd0);
        tick();
        rvalid = 1'b0; cq_wr_pvld = 1'b0; rid = '0;
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_eg2ig", 32'(eg2ig_axi_vld), 32'd0);
        chk("rst_err", 32'(eg_err), 32'd0);

        // 1: four full-line beats to thread 2
        ctx_write(4'd2, 7'h03, 1'b1);
        for (int k = 0; k < 4; k++) begin
            send_beat(8'h02, 16'hA000 + 16'(k), k == 3);
            chk("t1_valid", 32'(rsp_valid), 32'h004);
            chk("t1_pd", 32'(pd_of(2)), {14'd0, 2'b11, 16'hA000 + 16'(k)});
            chk("t1_eg2ig", 32'(eg2ig_axi_vld), 32'(k == 3));
        end
        tick();
        chk("t1_eg2ig_once", 32'(eg2ig_axi_vld), 32'd0);
        chk("t1_drained", 32'(rsp_valid), 32'd0);

        // 2: odd first beat, even last beat
        ctx_write(4'd5, 7'h31, 1'b1);
        send_beat(8'h05, 16'hB000, 1'b0);
        chk("t2_mask0", 32'(pd_of(5)), {14'd0, 2'b10, 16'hB000});
        send_beat(8'h05, 16'hB001, 1'b1);
        chk("t2_mask1", 32'(pd_of(5)), {14'd0, 2'b01, 16'hB001});
        chk("t2_eg2ig", 32'(eg2ig_axi_vld), 32'd1);
        tick();

        // 3: thread 1 backpressured, thread 3 keeps flowing
        rsp_ready[1] = 1'b0;
        ctx_write(4'd1, 7'h02, 1'b1);
        ctx_write(4'd3, 7'h00, 1'b1);
        send_beat(8'h01, 16'hC000, 1'b0);
        send_beat(8'h01, 16'hC001, 1'b0);
        chk("t3_head", 32'(pd_of(1)), {14'd0, 2'b11, 16'hC000});
        rvalid = 1'b1; rid = 8'h01; rdata = 16'hC002; rlast = 1'b1;
        #1;
        chk("t3_blocked", 32'(rready), 32'd0);
        tick();
        rid = 8'h03; rdata = 16'hD000; rlast = 1'b1;
        #1;
        chk("t3_other_rdy", 32'(rready), 32'd1);
        tick();
        chk("t3_other_pd", 32'(pd_of(3)), {14'd0, 2'b11, 16'hD000});
        chk("t3_other_eg2ig", 32'(eg2ig_axi_vld), 32'd1);
        rid = 8'h01; rdata = 16'hC002; rlast = 1'b1;
        rsp_ready[1] = 1'b1;
        #1;
        chk("t3_full_pop_rdy", 32'(rready), 32'd1);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        chk("t3_out1", 32'(pd_of(1)), {14'd0, 2'b11, 16'hC001});
        chk("t3_eg2ig", 32'(eg2ig_axi_vld), 32'd1);
        tick();
        chk("t3_out2", 32'(pd_of(1)), {14'd0, 2'b11, 16'hC002});
        chk("t3_valid2", 32'(rsp_valid), 32'h002);
        tick();
        chk("t3_empty", 32'(rsp_valid), 32'd0);

        // 4: interleaved bursts on threads 0 and 4
        ctx_write(4'd0, 7'h01, 1'b1);
        ctx_write(4'd4, 7'h01, 1'b1);
        send_beat(8'h00, 16'hE000, 1'b0);
        chk("t4_0a", 32'(pd_of(0)), {14'd0, 2'b11, 16'hE000});
        send_beat(8'h04, 16'hF000, 1'b0);
        chk("t4_4a", 32'(pd_of(4)), {14'd0, 2'b11, 16'hF000});
        chk("t4_no_pulse", 32'(eg2ig_axi_vld), 32'd0);
        send_beat(8'h00, 16'hE001, 1'b1);
        chk("t4_0b", 32'(pd_of(0)), {14'd0, 2'b11, 16'hE001});
        chk("t4_pulse0", 32'(eg2ig_axi_vld), 32'd1);
        send_beat(8'h04, 16'hF001, 1'b1);
        chk("t4_4b", 32'(pd_of(4)), {14'd0, 2'b11, 16'hF001});
        chk("t4_pulse4", 32'(eg2ig_axi_vld), 32'd1);
        tick();
        chk("t4_err", 32'(eg_err), 32'd0);

        // 5: out-of-range id dropped; early rlast
        send_beat(8'h0C, 16'h1234, 1'b1);
        chk("t5_oob_drop", 32'(rsp_valid), 32'd0);
        chk("t5_oob_err", 32'(eg_err), 32'(ERR_EN));
        do_reset();
        #1;
        chk("t5_err_clr", 32'(eg_err), 32'd0);
        ctx_write(4'd6, 7'h01, 1'b1);
        send_beat(8'h06, 16'h5555, 1'b1);
        chk("t5_early_pd", 32'(pd_of(6)), {14'd0, 2'b11, 16'h5555});
        chk("t5_early_err", 32'(eg_err), 32'(ERR_EN));

        // 6: context FIFO depth, reset mid-burst
        do_reset();
        for (int k = 0; k < 4; k++) ctx_write(4'd0, 7'h00, 1'b1);
        ctx_write(4'd0, 7'h00, 1'b0);
        rsp_ready[7] = 1'b0;
        ctx_write(4'd7, 7'h03, 1'b1);
        send_beat(8'h07, 16'h7777, 1'b0);
        chk("t6_held", 32'(rsp_valid), 32'h080);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cq_wr_thread_id = 4'd0;
        rvalid = 1'b1; rid = 8'h07;
        #1;
        chk("t6_rsp_clr", 32'(rsp_valid), 32'd0);
        chk("t6_prdy", 32'(cq_wr_prdy), 32'd1);
        chk("t6_no_ctx", 32'(rready), 32'd0);
        chk("t6_err", 32'(eg_err), 32'd0);
        rvalid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
